// File: rtl/comp_conv_pipe_pkg.sv
// Shared definitions for the sign-magnitude / two's complement converter.
package comp_conv_pipe_pkg;

  localparam logic MODE_SM2TC = 1'b0;
  localparam logic MODE_TC2SM = 1'b1;

endpackage

// File: rtl/comp_conv_core.sv
// Combinational SM <-> 2C conversion with detection of the two non-representable codes.
module comp_conv_core
  import comp_conv_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_data,
  output logic             o_nz,
  output logic             o_ovf
);

  localparam logic [WIDTH-2:0] ONE = (WIDTH-1)'(1);

  logic [WIDTH-2:0] w_mag;
  logic [WIDTH-2:0] w_neg;
  logic             w_sign;
  logic             w_mag_zero;

  // Negating the low bits is the same operation in both directions.
  assign w_sign     = i_data[WIDTH-1];
  assign w_mag      = i_data[WIDTH-2:0];
  assign w_neg      = (~w_mag) + ONE;
  assign w_mag_zero = (w_mag == '0);

  always_comb begin
    o_data = i_data;
    o_nz   = 1'b0;
    o_ovf  = 1'b0;
    if (w_sign) begin
      if (w_mag_zero) begin
        if (i_mode == MODE_SM2TC) begin
          o_data = '0;
          o_nz   = 1'b1;
        end else begin
          o_data = '1;
          o_ovf  = 1'b1;
        end
      end else begin
        o_data = {1'b1, w_neg};
      end
    end
  end

endmodule

// File: rtl/comp_conv_pipe.sv
// Two-stage valid/ready pipeline around comp_conv_core with saturating event counters.
module comp_conv_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nz,
  output logic             out_ovf,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_nz,
  output logic [CNT_W-1:0] cnt_ovf
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic             w_en;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_conv_data;
  logic             w_conv_nz;
  logic             w_conv_ovf;

  logic             r_vld_p1;
  logic [WIDTH-1:0] r_data_p1;
  logic             r_nz_p1;
  logic             r_ovf_p1;
  logic             r_vld_p2;
  logic [WIDTH-1:0] r_data_p2;
  logic             r_nz_p2;
  logic             r_ovf_p2;
  logic [CNT_W-1:0] r_cnt_nz;
  logic [CNT_W-1:0] r_cnt_ovf;

  comp_conv_core #(.WIDTH(WIDTH)) u_core (
    .i_data (in_data),
    .i_mode (in_mode),
    .o_data (w_conv_data),
    .o_nz   (w_conv_nz),
    .o_ovf  (w_conv_ovf)
  );

  // The whole pipe advances together; a stalled output freezes both stages.
  assign w_en       = ~r_vld_p2 | out_ready;
  assign w_out_xfer = r_vld_p2 & out_ready;
  assign in_ready   = w_en;

  // Stage p1: converted sample
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_data_p1 <= w_conv_data;
      r_nz_p1   <= w_conv_nz;
      r_ovf_p1  <= w_conv_ovf;
    end
  end

  // Stage p2: output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_nz_p2   <= 1'b0;
      r_ovf_p2  <= 1'b0;
    end else if (w_en) begin
      r_vld_p1  <= in_valid;
      r_vld_p2  <= r_vld_p1;
      r_data_p2 <= r_data_p1;
      r_nz_p2   <= r_nz_p1;
      r_ovf_p2  <= r_ovf_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      r_cnt_nz  <= '0;
      r_cnt_ovf <= '0;
    end else begin
      if (w_out_xfer && r_nz_p2)  r_cnt_nz  <= sat_inc(r_cnt_nz);
      if (w_out_xfer && r_ovf_p2) r_cnt_ovf <= sat_inc(r_cnt_ovf);
    end
  end

  assign out_valid = r_vld_p2;
  assign out_data  = r_data_p2;
  assign out_nz    = r_nz_p2;
  assign out_ovf   = r_ovf_p2;
  assign cnt_nz    = r_cnt_nz;
  assign cnt_ovf   = r_cnt_ovf;

endmodule

// File: tb/tb_comp_conv_pipe.sv
// Bench for comp_conv_pipe: directed values, round trip, backpressure, counters and reset.
module tb_comp_conv_pipe;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_nz;
  logic          out_ovf;
  logic          clr_cnt;
  logic [CW-1:0] cnt_nz;
  logic [CW-1:0] cnt_ovf;

  always #5 clk = ~clk;

  comp_conv_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nz    (out_nz),
    .out_ovf   (out_ovf),
    .clr_cnt   (clr_cnt),
    .cnt_nz    (cnt_nz),
    .cnt_ovf   (cnt_ovf)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         nz;
    logic         ovf;
    int           t;
  } exp_t;

  exp_t          sb[$];
  logic [W-1:0]  got_q[$];
  logic [W-1:0]  p1[256];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            n_out    = 0;
  logic          lat_chk  = 1'b0;
  logic [CW-1:0] m_nz     = '0;
  logic [CW-1:0] m_ovf    = '0;
  logic          hold_v   = 1'b0;
  logic [W-1:0]  hold_d   = '0;
  logic [W-1:0]  last_d   = '0;
  logic          last_nz  = 1'b0;
  logic          last_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference conversion from signed integer values.
  function automatic exp_t model(input logic [W-1:0] d, input logic mode);
    exp_t r;
    int   v;
    int   mag;
    r.d = '0; r.nz = 1'b0; r.ovf = 1'b0; r.t = 0;
    if (mode == 1'b0) begin
      mag  = int'(d[W-2:0]);
      v    = d[W-1] ? -mag : mag;
      r.d  = v[W-1:0];
      r.nz = d[W-1] && (mag == 0);
    end else begin
      v = int'($signed(d));
      if (v == -(1 << (W-1))) begin
        r.d   = '1;
        r.ovf = 1'b1;
      end else begin
        mag = (v < 0) ? -v : v;
        r.d = {(v < 0), mag[W-2:0]};
      end
    end
    return r;
  endfunction

  // One clock: observe transfers at the current inputs, advance, check counters.
  task automatic cycle();
    logic ix;
    logic ox;
    exp_t e;
    #1;
    ix = rst_n && in_valid && in_ready;
    ox = rst_n && out_valid && out_ready;
    if (hold_v && rst_n) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_stable", out_data, hold_d);
    end
    hold_v = rst_n && out_valid && !out_ready;
    hold_d = out_data;
    if (ox) begin
      n_out++;
      last_d = out_data; last_nz = out_nz; last_ovf = out_ovf;
      got_q.push_back(out_data);
      chk("output_has_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_nz", out_nz, e.nz);
        chk("out_ovf", out_ovf, e.ovf);
        if (lat_chk) chk("latency", cyc - e.t, 2);
        if (e.nz && m_nz != '1) m_nz++;
        if (e.ovf && m_ovf != '1) m_ovf++;
      end
    end
    if (!rst_n) begin
      sb.delete(); m_nz = '0; m_ovf = '0;
    end else if (clr_cnt) begin
      m_nz = '0; m_ovf = '0;
    end
    if (ix) begin
      e = model(in_data, in_mode);
      e.t = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("cnt_nz", cnt_nz, m_nz);
    chk("cnt_ovf", cnt_ovf, m_ovf);
  endtask

  task automatic send(input logic [W-1:0] d, input logic m);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_mode = m;
    for (int k = 0; k < 20; k++) begin
      #1;
      acc = in_ready;
      cycle();
      if (acc) break;
    end
    chk("send_accepted", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 0; k < 40 && sb.size() > 0; k++) cycle();
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic expect_val(input string tag, input logic [W-1:0] d, input logic m,
                            input logic [W-1:0] ed, input logic enz, input logic eovf);
    int n0;
    n0 = n_out;
    send(d, m);
    drain();
    chk({tag, "_count"}, n_out - n0, 1);
    chk({tag, "_data"}, last_d, ed);
    chk({tag, "_nz"}, last_nz, enz);
    chk({tag, "_ovf"}, last_ovf, eovf);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_nz", out_nz, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_cnt_nz", cnt_nz, 0);
    chk("rst_cnt_ovf", cnt_ovf, 0);

    expect_val("m0_85", 8'h85, 1'b0, 8'hFB, 1'b0, 1'b0);
    expect_val("m0_23", 8'h23, 1'b0, 8'h23, 1'b0, 1'b0);
    expect_val("m0_FF", 8'hFF, 1'b0, 8'h81, 1'b0, 1'b0);
    expect_val("m0_80", 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("m0_80_cnt_nz", cnt_nz, 1);
    expect_val("m1_FB", 8'hFB, 1'b1, 8'h85, 1'b0, 1'b0);
    expect_val("m1_81", 8'h81, 1'b1, 8'hFF, 1'b0, 1'b0);
    expect_val("m1_80", 8'h80, 1'b1, 8'hFF, 1'b0, 1'b1);
    chk("m1_80_cnt_ovf", cnt_ovf, 1);
    expect_val("m1_7F", 8'h7F, 1'b1, 8'h7F, 1'b0, 1'b0);

    // Exhaustive round trip, streamed back to back.
    lat_chk = 1'b1;
    got_q.delete();
    for (int i = 0; i < 256; i++) send(W'(i), 1'b0);
    drain();
    chk("rt_pass1_count", got_q.size(), 256);
    for (int i = 0; i < 256; i++) p1[i] = (i < got_q.size()) ? got_q[i] : '0;
    got_q.delete();
    for (int i = 0; i < 256; i++) send(p1[i], 1'b1);
    drain();
    chk("rt_pass2_count", got_q.size(), 256);
    for (int i = 0; i < 256 && i < got_q.size(); i++)
      chk("rt_value", got_q[i], (i == 8'h80) ? 32'h0 : i);
    lat_chk = 1'b0;

    // Backpressure with in_valid held high.
    in_valid = 1'b1; in_data = W'($urandom); in_mode = 1'($urandom);
    for (int k = 0; k < 14; k++) begin
      out_ready = !(k >= 4 && k < 9);
      #1;
      acc = in_ready;
      if (k >= 4 && k < 9) chk("bp_in_ready", in_ready, 0);
      cycle();
      if (acc) begin
        in_data = W'($urandom);
        in_mode = 1'($urandom);
      end
    end
    drain();

    // Reset with two samples in flight.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h80; in_mode = 1'b1;
    cycle();
    in_data = 8'h80; in_mode = 1'b0;
    cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_cnt_nz", cnt_nz, 0);
    chk("midrst_cnt_ovf", cnt_ovf, 0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("midrst_no_output", out_valid, 0);
    end
    expect_val("post_rst", 8'h23, 1'b0, 8'h23, 1'b0, 1'b0);

    // Saturation and clear priority.
    for (int i = 0; i < 20; i++) send(8'h80, 1'b0);
    drain();
    chk("cnt_nz_sat", cnt_nz, 15);
    send(8'h80, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) cycle();
    chk("clr_out_valid", out_valid, 1);
    out_ready = 1'b1;
    clr_cnt = 1'b1;
    begin
      int n0;
      n0 = n_out;
      cycle();
      chk("clr_xfer", n_out - n0, 1);
    end
    clr_cnt = 1'b0;
    chk("clr_cnt_nz", cnt_nz, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
